// File: rtl/apb_uart_initiator.sv
// rtl/apb_uart_initiator.sv - valid/ready command to two-phase APB requester for the UART register window
module apb_uart_initiator #(
  parameter int                ADDR_W      = 12,
  parameter int                WDATA_W     = 8,
  parameter int                RDATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 12'h400,
  parameter logic [ADDR_W-1:0] LAST_ADDR   = 12'h41C,
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [WDATA_W-1:0] cmd_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [RDATA_W-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               busy,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [ADDR_W-1:0]  PADDR,
  output logic [WDATA_W-1:0] PWDATA,
  input  logic               PREADY,
  input  logic [RDATA_W-1:0] PRDATA
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] tcnt;
  logic             addr_ok;

  assign addr_ok = (cmd_addr[1:0] == 2'b00) && (cmd_addr >= BASE_ADDR) && (cmd_addr <= LAST_ADDR);

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      tcnt      <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            PWRITE    <= cmd_write;
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_wdata;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (addr_ok) begin
              state <= ST_SETUP;
              PSEL  <= 1'b1;
            end else begin
              // Bad address never reaches the bus
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          PENABLE <= 1'b1;
          tcnt    <= '0;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            state     <= ST_RESP;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
          end else if (tcnt == CNT_LAST) begin
            // This edge is the TIMEOUT_CYC-th not-ready ACCESS cycle
            state     <= ST_RESP;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_initiator.sv
// tb/tb_apb_uart_initiator.sv - directed bench for apb_uart_initiator
module tb_apb_uart_initiator;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [11:0] PADDR;
  logic [7:0]  PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;

  int total = 0;
  int bad   = 0;

  apb_uart_initiator #(.TIMEOUT_CYC(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PREADY = 1'b1; PRDATA = '0;
    step(); step();
    total++; if (PSEL !== 1'b0) begin bad++; $display("FAIL rst_psel got=%b exp=0", PSEL); end
    total++; if (PENABLE !== 1'b0) begin bad++; $display("FAIL rst_penable got=%b exp=0", PENABLE); end
    total++; if (PWRITE !== 1'b0) begin bad++; $display("FAIL rst_pwrite got=%b exp=0", PWRITE); end
    total++; if (PADDR !== 12'h000) begin bad++; $display("FAIL rst_paddr got=%h exp=000", PADDR); end
    total++; if (PWDATA !== 8'h00) begin bad++; $display("FAIL rst_pwdata got=%h exp=00", PWDATA); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    PRESETn = 1'b1;
    step();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write();
    PREADY = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h410; cmd_wdata = 8'hD8;
    step();
    cmd_valid = 1'b0;
    total++; if ({PSEL, PENABLE} !== 2'b10) begin bad++; $display("FAIL wr_setup got=%b exp=10", {PSEL, PENABLE}); end
    total++; if (PADDR !== 12'h410) begin bad++; $display("FAIL wr_setup_paddr got=%h exp=410", PADDR); end
    total++; if (PWRITE !== 1'b1) begin bad++; $display("FAIL wr_setup_pwrite got=%b exp=1", PWRITE); end
    total++; if (PWDATA !== 8'hD8) begin bad++; $display("FAIL wr_setup_pwdata got=%h exp=d8", PWDATA); end
    total++; if ({cmd_ready, busy} !== 2'b01) begin bad++; $display("FAIL wr_busy got=%b exp=01", {cmd_ready, busy}); end
    step();
    total++; if ({PSEL, PENABLE} !== 2'b11) begin bad++; $display("FAIL wr_access got=%b exp=11", {PSEL, PENABLE}); end
    total++; if ({PADDR, PWDATA} !== {12'h410, 8'hD8}) begin bad++; $display("FAIL wr_access_bus got=%h exp=410d8", {PADDR, PWDATA}); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_early_rsp got=%b exp=0", rsp_valid); end
    step();
    total++; if ({rsp_valid, rsp_err} !== 2'b10) begin bad++; $display("FAIL wr_rsp got=%b exp=10", {rsp_valid, rsp_err}); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_rsp_rdata got=%h exp=0", rsp_rdata); end
    total++; if ({PSEL, PENABLE} !== 2'b00) begin bad++; $display("FAIL wr_resp_bus got=%b exp=00", {PSEL, PENABLE}); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    total++; if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin bad++; $display("FAIL wr_done got=%b exp=010", {rsp_valid, cmd_ready, busy}); end
  endtask

  task automatic test_wait_states();
    int pen_cnt;
    pen_cnt = 0;
    PREADY = 1'b0; PRDATA = 32'h1111_1111;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h404; cmd_wdata = 8'hFF;
    step();
    cmd_valid = 1'b0;
    total++; if ({PSEL, PENABLE, PWRITE} !== 3'b100) begin bad++; $display("FAIL ws_setup got=%b exp=100", {PSEL, PENABLE, PWRITE}); end
    step();
    for (int k = 1; k <= 4; k++) begin
      if (PENABLE === 1'b1 && PSEL === 1'b1) pen_cnt++;
      total++; if (PADDR !== 12'h404) begin bad++; $display("FAIL ws_paddr_stable got=%h exp=404", PADDR); end
      if (k == 4) begin PREADY = 1'b1; PRDATA = 32'h0000_00A5; end
      step();
    end
    total++; if (pen_cnt !== 4) begin bad++; $display("FAIL ws_penable_cycles got=%0d exp=4", pen_cnt); end
    total++; if ({rsp_valid, rsp_err} !== 2'b10) begin bad++; $display("FAIL ws_rsp got=%b exp=10", {rsp_valid, rsp_err}); end
    total++; if (rsp_rdata !== 32'h0000_00A5) begin bad++; $display("FAIL ws_rdata got=%h exp=000000a5", rsp_rdata); end
    total++; if (PENABLE !== 1'b0) begin bad++; $display("FAIL ws_penable_drop got=%b exp=0", PENABLE); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int pen_cnt;
    pen_cnt = 0;
    PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h400;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) begin
      step();
      if (PENABLE === 1'b1) pen_cnt++;
    end
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL to_no_rsp got=%b exp=1", rsp_valid); end
    total++; if (pen_cnt !== 16) begin bad++; $display("FAIL to_access_cycles got=%0d exp=16", pen_cnt); end
    total++; if ({PSEL, PENABLE} !== 2'b00) begin bad++; $display("FAIL to_bus_drop got=%b exp=00", {PSEL, PENABLE}); end
    total++; if ({rsp_err, rsp_rdata} !== {1'b1, 32'h0}) begin bad++; $display("FAIL to_rsp got=%b/%h exp=1/0", rsp_err, rsp_rdata); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    // PREADY arriving on the 16th ACCESS cycle still succeeds
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h400;
    step();
    cmd_valid = 1'b0;
    step();
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) begin PREADY = 1'b1; PRDATA = 32'h0000_0077; end
      step();
    end
    total++; if ({rsp_valid, rsp_err} !== 2'b10) begin bad++; $display("FAIL to_edge_rsp got=%b exp=10", {rsp_valid, rsp_err}); end
    total++; if (rsp_rdata !== 32'h0000_0077) begin bad++; $display("FAIL to_edge_rdata got=%h exp=00000077", rsp_rdata); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_bad_addr();
    logic [11:0] addrs [4];
    addrs[0] = 12'h402; addrs[1] = 12'h500; addrs[2] = 12'h3FC; addrs[3] = 12'h420;
    PREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addrs[i];
      step();
      cmd_valid = 1'b0;
      total++; if ({rsp_valid, rsp_err, PSEL} !== 3'b110) begin bad++; $display("FAIL bad_addr_%h got=%b exp=110", addrs[i], {rsp_valid, rsp_err, PSEL}); end
      total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL bad_addr_rdata_%h got=%h exp=0", addrs[i], rsp_rdata); end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      total++; if ({PSEL, cmd_ready} !== 2'b01) begin bad++; $display("FAIL bad_addr_after_%h got=%b exp=01", addrs[i], {PSEL, cmd_ready}); end
    end
    PRDATA = 32'hCAFE_F00D;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h41C;
    step();
    cmd_valid = 1'b0;
    total++; if (PSEL !== 1'b1) begin bad++; $display("FAIL last_addr_psel got=%b exp=1", PSEL); end
    step(); step();
    total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hCAFE_F00D}) begin bad++; $display("FAIL last_addr_rsp got=%b%b/%h exp=10/cafef00d", rsp_valid, rsp_err, rsp_rdata); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    PREADY = 1'b1; PRDATA = 32'h1234_5678;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h408;
    step();
    cmd_write = 1'b1; cmd_addr = 12'h400; cmd_wdata = 8'h5A;
    step(); step();
    PRDATA = 32'h0;
    for (int i = 0; i < 5; i++) begin
      total++; if ({rsp_valid, cmd_ready, PSEL} !== 3'b100) begin bad++; $display("FAIL bp_hold_%0d got=%b exp=100", i, {rsp_valid, cmd_ready, PSEL}); end
      total++; if (rsp_rdata !== 32'h1234_5678) begin bad++; $display("FAIL bp_rdata_%0d got=%h exp=12345678", i, rsp_rdata); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    total++; if ({rsp_valid, cmd_ready, PSEL} !== 3'b010) begin bad++; $display("FAIL bp_release got=%b exp=010", {rsp_valid, cmd_ready, PSEL}); end
    step();
    cmd_valid = 1'b0;
    total++; if ({PSEL, PWRITE, PADDR, PWDATA} !== {2'b11, 12'h400, 8'h5A}) begin bad++; $display("FAIL bp_second got=%h exp=%h", {PSEL, PWRITE, PADDR, PWDATA}, {2'b11, 12'h400, 8'h5A}); end
    step(); step();
    total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0}) begin bad++; $display("FAIL bp_second_rsp got=%b%b/%h exp=10/0", rsp_valid, rsp_err, rsp_rdata); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    PREADY = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h400;
    step();
    cmd_valid = 1'b0;
    step();
    total++; if ({PSEL, PENABLE} !== 2'b11) begin bad++; $display("FAIL rm_access got=%b exp=11", {PSEL, PENABLE}); end
    PRESETn = 1'b0;
    step();
    PRESETn = 1'b1;
    total++; if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin bad++; $display("FAIL rm_abandon got=%b exp=000", {PSEL, PENABLE, rsp_valid}); end
    PREADY = 1'b1;
    step();
    total++; if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin bad++; $display("FAIL rm_release got=%b exp=100", {cmd_ready, rsp_valid, busy}); end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h408; cmd_wdata = 8'h3C;
    step();
    cmd_valid = 1'b0;
    total++; if ({PSEL, PENABLE, PADDR, PWDATA} !== {2'b10, 12'h408, 8'h3C}) begin bad++; $display("FAIL rm_wr_setup got=%h exp=%h", {PSEL, PENABLE, PADDR, PWDATA}, {2'b10, 12'h408, 8'h3C}); end
    step(); step();
    total++; if ({rsp_valid, rsp_err} !== 2'b10) begin bad++; $display("FAIL rm_wr_rsp got=%b exp=10", {rsp_valid, rsp_err}); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_wait_states();
    test_timeout();
    test_bad_addr();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
